mem_port_arbiter: RTL and testbench

//  Shares the single-ported, variable-latency unified memory between instruction fetch (IF) and the

---
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch (IF) and data memory (DM).
// One access in flight at a time; DM has priority; freezes after HALT until reset.
module mem_port_arbiter #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          halt,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_err,
  input  logic          dm_req,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          dm_err,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_done,
  output logic          halted
);

  localparam int unsigned CW = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IF_BUSY,
    S_DM_BUSY,
    S_RESP,
    S_HALTED
  } state_t;

  state_t        state_q, state_d;
  logic          cur_dm_q, cur_dm_d;
  logic          cur_wr_q, cur_wr_d;
  logic          mask_q, mask_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [DW-1:0] if_rdata_d, dm_rdata_d, mem_wdata_d;
  logic [AW-1:0] mem_addr_d;
  logic          if_done_d, if_err_d, dm_done_d, dm_err_d;
  logic          mem_en_d, mem_wr_d, halted_d;
  logic          if_eff, dm_eff;

  // The port served by the last response is ignored for one arbitration cycle.
  assign if_eff = if_req & ~(mask_q & ~cur_dm_q);
  assign dm_eff = dm_req & ~(mask_q & cur_dm_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cur_dm_q  <= 1'b0;
      cur_wr_q  <= 1'b0;
      mask_q    <= 1'b0;
      cnt_q     <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_done   <= 1'b0;
      if_err    <= 1'b0;
      dm_done   <= 1'b0;
      dm_err    <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_dm_q  <= cur_dm_d;
      cur_wr_q  <= cur_wr_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      if_rdata  <= if_rdata_d;
      dm_rdata  <= dm_rdata_d;
      if_done   <= if_done_d;
      if_err    <= if_err_d;
      dm_done   <= dm_done_d;
      dm_err    <= dm_err_d;
      mem_en    <= mem_en_d;
      mem_wr    <= mem_wr_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      halted    <= halted_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_dm_d    = cur_dm_q;
    cur_wr_d    = cur_wr_q;
    mask_d      = 1'b0;
    cnt_d       = cnt_q;
    if_rdata_d  = if_rdata;
    dm_rdata_d  = dm_rdata;
    if_done_d   = 1'b0;
    if_err_d    = 1'b0;
    dm_done_d   = 1'b0;
    dm_err_d    = 1'b0;
    mem_en_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    halted_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (halt) begin
          state_d  = S_HALTED;
          halted_d = 1'b1;
        end else if (dm_eff) begin
          cur_dm_d = 1'b1;
          if (dm_addr[0]) begin
            state_d   = S_RESP;
            dm_done_d = 1'b1;
            dm_err_d  = 1'b1;
          end else begin
            state_d     = S_DM_BUSY;
            cur_wr_d    = dm_wr;
            cnt_d       = '0;
            mem_en_d    = 1'b1;
            mem_wr_d    = dm_wr;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
          end
        end else if (if_eff) begin
          cur_dm_d = 1'b0;
          if (if_addr[0]) begin
            state_d   = S_RESP;
            if_done_d = 1'b1;
            if_err_d  = 1'b1;
          end else begin
            state_d    = S_IF_BUSY;
            cur_wr_d   = 1'b0;
            cnt_d      = '0;
            mem_en_d   = 1'b1;
            mem_addr_d = if_addr;
          end
        end
      end

      S_IF_BUSY, S_DM_BUSY: begin
        if (mem_done) begin
          state_d = S_RESP;
          if (cur_dm_q) begin
            dm_done_d = 1'b1;
            if (!cur_wr_q) dm_rdata_d = mem_rdata;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d   = S_RESP;
          dm_done_d = cur_dm_q;
          dm_err_d  = cur_dm_q;
          if_done_d = ~cur_dm_q;
          if_err_d  = ~cur_dm_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_RESP: begin
        mask_d   = 1'b1;
        halted_d = halt;
        state_d  = halt ? S_HALTED : S_IDLE;
      end

      S_HALTED: begin
        halted_d = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level reference model plus directed scenarios.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic [15:0] if_rdata;
    logic [15:0] dm_rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        if_done;
    logic        if_err;
    logic        dm_done;
    logic        dm_err;
    logic        mem_en;
    logic        mem_wr;
    logic        halted;
  } out_t;

  logic        clk, rst_n, halt;
  logic        if_req, dm_req, dm_wr, mem_done;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_done, if_err, dm_done, dm_err, mem_en, mem_wr, halted;

  mem_port_arbiter #(.AW(16), .DW(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_err(if_err),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_err(dm_err),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: which port owns the memory, how long it has waited, who was just answered.
  out_t ex;
  int   busy_port;   // 0 none, 1 IF, 2 DM
  int   busy_age;
  bit   busy_store;
  int   resp_port;
  int   masked;
  bit   frozen;
  int   cyc = 0;
  int   done_at = -1;
  bit   directed;
  int   forced_delay;
  logic [15:0] forced_rdata;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("if_done", 16'(if_done), 16'(ex.if_done));
    chk("if_err", 16'(if_err), 16'(ex.if_err));
    chk("dm_done", 16'(dm_done), 16'(ex.dm_done));
    chk("dm_err", 16'(dm_err), 16'(ex.dm_err));
    chk("if_rdata", if_rdata, ex.if_rdata);
    chk("dm_rdata", dm_rdata, ex.dm_rdata);
    chk("mem_en", 16'(mem_en), 16'(ex.mem_en));
    chk("mem_wr", 16'(mem_wr & mem_en), 16'(ex.mem_wr));
    chk("mem_addr", mem_addr, ex.mem_addr);
    chk("halted", 16'(halted), 16'(ex.halted));
    if (ex.mem_en && ex.mem_wr) chk("mem_wdata", mem_wdata, ex.mem_wdata);
  endtask

  task automatic model_reset();
    ex = '0;
    busy_port = 0; busy_age = 0; busy_store = 1'b0;
    resp_port = 0; masked = 0; frozen = 1'b0; done_at = -1;
  endtask

  task automatic respond(inout out_t o, input int p, input bit err);
    if (p == 1) begin o.if_done = 1'b1; o.if_err = err; end
    else begin o.dm_done = 1'b1; o.dm_err = err; end
    resp_port = p;
    busy_port = 0;
    done_at   = -1;
  endtask

  task automatic step();
    out_t nx;
    int   m, d;
    logic [15:0] a;
    nx = ex;
    nx.if_done = 1'b0; nx.if_err = 1'b0; nx.dm_done = 1'b0; nx.dm_err = 1'b0;
    nx.mem_en = 1'b0; nx.mem_wr = 1'b0;
    if (frozen) begin
      nx.halted = 1'b1;
    end else if (busy_port != 0) begin
      if (mem_done) begin
        if (busy_port == 1) nx.if_rdata = mem_rdata;
        else if (!busy_store) nx.dm_rdata = mem_rdata;
        respond(nx, busy_port, 1'b0);
      end else begin
        busy_age++;
        if (busy_age == TIMEOUT) respond(nx, busy_port, 1'b1);
      end
    end else if (resp_port != 0) begin
      masked = resp_port;
      resp_port = 0;
      if (halt) begin frozen = 1'b1; nx.halted = 1'b1; end
    end else begin
      m = masked;
      masked = 0;
      if (halt) begin
        frozen = 1'b1; nx.halted = 1'b1;
      end else if ((dm_req && m != 2) || (if_req && m != 1)) begin
        m = (dm_req && m != 2) ? 2 : 1;
        a = (m == 2) ? dm_addr : if_addr;
        if (a[0]) begin
          respond(nx, m, 1'b1);
        end else begin
          busy_port  = m;
          busy_age   = 0;
          busy_store = (m == 2) && dm_wr;
          nx.mem_en   = 1'b1;
          nx.mem_wr   = busy_store;
          nx.mem_addr = a;
          if (m == 2) nx.mem_wdata = dm_wdata;
          if (directed) d = forced_delay;
          else d = ($urandom_range(15, 0) == 0) ? 100 : $urandom_range(4, 1);
          done_at = cyc + 1 + d;
        end
      end
    end
    ex = nx;
  endtask

  // One clock: check current outputs, advance the model, then drive memory for the next cycle.
  task automatic tick();
    @(negedge clk);
    compare();
    if (rst_n) step();
    @(posedge clk);
    #1;
    cyc++;
    mem_done = (done_at == cyc);
    if (!directed && done_at < 0 && busy_port == 0 && $urandom_range(7, 0) == 0) mem_done = 1'b1;
    mem_rdata = directed ? forced_rdata : 16'($urandom);
  endtask

  task automatic do_reset(input int ncyc);
    rst_n = 1'b0;
    halt = 1'b0;
    mem_done = 1'b0;
    #1;
    chk("rst_rdata", if_rdata | dm_rdata, 16'h0000);
    chk("rst_mem_bus", mem_addr | mem_wdata, 16'h0000);
    chk("rst_pulses", 16'({if_done, if_err, dm_done, dm_err, mem_en, mem_wr, halted}), 16'h0000);
    model_reset();
    repeat (ncyc) tick();
    rst_n = 1'b1;
  endtask

  task automatic new_if_addr();
    if_addr = (16'($urandom) & 16'hFFFE) | 16'($urandom_range(7, 0) == 0);
  endtask

  task automatic new_dm();
    dm_addr  = (16'($urandom) & 16'hFFFE) | 16'($urandom_range(7, 0) == 0);
    dm_wr    = 1'($urandom_range(1, 0));
    dm_wdata = 16'($urandom);
  endtask

  // Requesters hold until their done, then either reissue at once or go quiet.
  task automatic rand_inputs();
    if (if_req) begin
      if (ex.if_done) begin
        if ($urandom_range(1, 0) == 1) new_if_addr();
        else if_req = 1'b0;
      end
    end else if ($urandom_range(2, 0) == 0) begin
      if_req = 1'b1; new_if_addr();
    end
    if (dm_req) begin
      if (ex.dm_done) begin
        if ($urandom_range(1, 0) == 1) new_dm();
        else dm_req = 1'b0;
      end
    end else if ($urandom_range(3, 0) == 0) begin
      dm_req = 1'b1; new_dm();
    end
  endtask

  initial begin
    int halt_at;
    rst_n = 1'b0; halt = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_done = 1'b0; mem_rdata = '0;
    directed = 1'b1; forced_delay = 1; forced_rdata = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset(2);

    // Lone fetch, memory answers two cycles after launch.
    forced_delay = 2; forced_rdata = 16'hA5C3;
    if_req = 1'b1; if_addr = 16'h0010;
    tick();
    chk("t1_mem_en", 16'(mem_en), 16'h0001);
    chk("t1_mem_addr", mem_addr, 16'h0010);
    repeat (3) tick();
    chk("t1_if_done", 16'(if_done), 16'h0001);
    chk("t1_if_rdata", if_rdata, 16'hA5C3);
    chk("t1_if_err", 16'(if_err), 16'h0000);
    if_req = 1'b0;
    repeat (2) tick();

    // Simultaneous requests: the DM store goes first, fetch follows.
    forced_delay = 1; forced_rdata = 16'h7E57;
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0040; dm_wdata = 16'h1234;
    if_req = 1'b1; if_addr = 16'h0020;
    tick();
    chk("t2_mem_en", 16'(mem_en), 16'h0001);
    chk("t2_mem_wr", 16'(mem_wr), 16'h0001);
    chk("t2_mem_addr", mem_addr, 16'h0040);
    chk("t2_mem_wdata", mem_wdata, 16'h1234);
    repeat (2) tick();
    chk("t2_dm_done", 16'(dm_done), 16'h0001);
    chk("t2_if_not_done", 16'(if_done), 16'h0000);
    dm_req = 1'b0;
    repeat (2) tick();
    chk("t2_if_launch", 16'(mem_en), 16'h0001);
    chk("t2_if_addr", mem_addr, 16'h0020);
    chk("t2_if_rd", 16'(mem_wr), 16'h0000);
    repeat (2) tick();
    chk("t2_if_done", 16'(if_done), 16'h0001);
    chk("t2_if_rdata", if_rdata, 16'h7E57);
    if_req = 1'b0;
    repeat (2) tick();

    // Memory never answers: timeout after 15 busy cycles, then a load proceeds normally.
    forced_delay = 100;
    if_req = 1'b1; if_addr = 16'h0030;
    tick();
    chk("t4_mem_en", 16'(mem_en), 16'h0001);
    repeat (14) tick();
    chk("t4_not_yet", 16'(if_done), 16'h0000);
    tick();
    chk("t4_if_done", 16'(if_done), 16'h0001);
    chk("t4_if_err", 16'(if_err), 16'h0001);
    if_req = 1'b0;
    forced_delay = 1; forced_rdata = 16'hBEEF;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0050;
    repeat (2) tick();
    chk("t4_next_en", 16'(mem_en), 16'h0001);
    chk("t4_next_addr", mem_addr, 16'h0050);
    repeat (2) tick();
    chk("t4_dm_done", 16'(dm_done), 16'h0001);
    chk("t4_dm_rdata", dm_rdata, 16'hBEEF);
    dm_req = 1'b0;
    repeat (2) tick();

    // Misaligned load: immediate error, no memory access, load data kept.
    forced_rdata = 16'h1111;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0041;
    tick();
    chk("t3_dm_done", 16'(dm_done), 16'h0001);
    chk("t3_dm_err", 16'(dm_err), 16'h0001);
    chk("t3_no_mem_en", 16'(mem_en), 16'h0000);
    chk("t3_dm_rdata", dm_rdata, 16'hBEEF);
    dm_req = 1'b0;
    repeat (2) tick();

    // HALT while the data access is in flight: it completes, then the arbiter freezes.
    forced_delay = 3; forced_rdata = 16'h600D;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0060;
    tick();
    chk("t5_mem_en", 16'(mem_en), 16'h0001);
    halt = 1'b1;
    repeat (4) tick();
    chk("t5_dm_done", 16'(dm_done), 16'h0001);
    chk("t5_dm_rdata", dm_rdata, 16'h600D);
    chk("t5_not_halted", 16'(halted), 16'h0000);
    dm_req = 1'b0;
    if_req = 1'b1; if_addr = 16'h0010;
    tick();
    chk("t5_halted", 16'(halted), 16'h0001);
    repeat (5) tick();
    chk("t5_no_grant", 16'(mem_en | if_done), 16'h0000);
    if_req = 1'b0;

    // Reset in the middle of a fetch, then the still-pending fetch relaunches.
    do_reset(1);
    forced_delay = 5; forced_rdata = 16'hC0DE;
    if_req = 1'b1; if_addr = 16'h0070;
    repeat (2) tick();
    do_reset(2);
    tick();
    chk("t6_relaunch", 16'(mem_en), 16'h0001);
    chk("t6_addr", mem_addr, 16'h0070);
    repeat (6) tick();
    chk("t6_if_done", 16'(if_done), 16'h0001);
    chk("t6_if_rdata", if_rdata, 16'hC0DE);
    if_req = 1'b0;
    repeat (2) tick();

    // Randomized traffic, some segments ending in HALT, occasional mid-run resets.
    directed = 1'b0;
    for (int seg = 0; seg < 4; seg++) begin
      do_reset(1);
      halt_at = (seg % 2 == 1) ? $urandom_range(320, 200) : -1;
      for (int i = 0; i < 350; i++) begin
        if (i == halt_at) halt = 1'b1;
        if (i > 20 && $urandom_range(299, 0) == 0) do_reset(1);
        rand_inputs();
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
